// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache that
// sits between the MEM stage and a slower handshaked backing memory.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cpu_read, cpu_write   MEM-stage MemRead / MemWrite (both set = write)
//   cpu_addr, cpu_wdata   byte address (bits [1:0] ignored) and store data
//   cpu_rdata             load data, valid when cpu_read=1 and cpu_stall=0
//   cpu_stall             freezes the pipeline while the cache is busy
//   mem_req, mem_we       registered request / direction to backing memory
//   mem_addr, mem_wdata   registered word-aligned address and write data
//   mem_rdata, mem_ack    backing-memory read data and one-cycle completion
//   dbg_state             current FSM state (0 IDLE, 1 FILL, 2 WDONE)
//
// Handshake: a request is presented by holding mem_req=1 with mem_we,
// mem_addr and mem_wdata stable; it completes at the rising edge where
// mem_ack=1, after which mem_req drops for at least one cycle. mem_ack is
// ignored while mem_req=0.
module dcache_wt #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  dbg_state
);
    localparam int INDEX_BITS = $clog2(LINES);
    localparam int TAG_BITS   = 30 - INDEX_BITS;

    // FILL covers both the read fill and the write-through; mem_we tells
    // which one is in flight.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WDONE = 2'd2
    } state_t;

    state_t state;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    logic [INDEX_BITS-1:0] cpu_index;
    logic [TAG_BITS-1:0]   cpu_tag;
    logic                  cpu_hit;
    logic [INDEX_BITS-1:0] lat_index;
    logic [TAG_BITS-1:0]   lat_tag;
    logic                  lat_hit;
    logic                  unused_addr_lsbs;

    assign cpu_index = cpu_addr[INDEX_BITS+1:2];
    assign cpu_tag   = cpu_addr[31:INDEX_BITS+2];
    assign cpu_hit   = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);

    // The write-through decides whether to update the line from the latched
    // address, not the live CPU address.
    assign lat_index = mem_addr[INDEX_BITS+1:2];
    assign lat_tag   = mem_addr[31:INDEX_BITS+2];
    assign lat_hit   = valid_q[lat_index] && (tag_q[lat_index] == lat_tag);

    assign unused_addr_lsbs = ^cpu_addr[1:0];
    assign dbg_state        = state;

    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = 32'd0;
        case (state)
            ST_IDLE: begin
                if (cpu_write) begin
                    cpu_stall = 1'b1;
                end else if (cpu_read) begin
                    if (cpu_hit) cpu_rdata = data_q[cpu_index];
                    else         cpu_stall = 1'b1;
                end
            end
            ST_FILL:  cpu_stall = 1'b1;
            ST_WDONE: cpu_stall = 1'b0;
            default:  cpu_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Abandons any in-flight request; arrays are left untouched
            // apart from the valid bits.
            state     <= ST_IDLE;
            valid_q   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_write) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {cpu_addr[31:2], 2'b00};
                        mem_wdata <= cpu_wdata;
                        state     <= ST_FILL;
                    end else if (cpu_read && !cpu_hit) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {cpu_addr[31:2], 2'b00};
                        state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            data_q[lat_index]  <= mem_rdata;
                            tag_q[lat_index]   <= lat_tag;
                            valid_q[lat_index] <= 1'b1;
                            state              <= ST_IDLE;
                        end else begin
                            // No write-allocate: only an already-cached word
                            // is refreshed.
                            if (lat_hit) data_q[lat_index] <= mem_wdata;
                            state <= ST_WDONE;
                        end
                    end
                end
                ST_WDONE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: directed per-cycle vector table for dcache_wt plus a
// hand-written variable-latency read miss.
module tb_dcache_wt;
    logic        clk;
    logic        reset;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [1:0]  dbg_state;

    int errors;
    int checks;

    logic [31:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        ack;
        logic [31:0] mrd;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    dcache_wt #(.LINES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic ack, input logic [31:0] mrd,
                       input logic e_stall, input logic e_req, input logic e_we,
                       input logic [31:0] e_addr, input logic [31:0] e_wd,
                       input logic chk_rd, input logic [31:0] e_rd);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd;
        v.ack = ack; v.mrd = mrd; v.e_stall = e_stall; v.e_req = e_req;
        v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
        v.chk_rd = chk_rd; v.e_rd = e_rd;
        vecs.push_back(v);
    endtask

    // Driver: inputs change on the falling edge, outputs are sampled 1ns later.
    task automatic drive(input vec_t v);
        reset     = v.rst;
        cpu_read  = v.rd;
        cpu_write = v.wr;
        cpu_addr  = v.addr;
        cpu_wdata = v.wd;
        mem_ack   = v.ack;
        mem_rdata = v.mrd;
    endtask

    task automatic run_vector(input int i, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check($sformatf("v%0d stall", i), {31'd0, cpu_stall}, {31'd0, v.e_stall});
        check($sformatf("v%0d mem_req", i), {31'd0, mem_req}, {31'd0, v.e_req});
        if (v.e_req) begin
            check($sformatf("v%0d mem_we", i), {31'd0, mem_we}, {31'd0, v.e_we});
            check($sformatf("v%0d mem_addr", i), mem_addr, v.e_addr);
            if (v.e_we) check($sformatf("v%0d mem_wdata", i), mem_wdata, v.e_wd);
        end
        if (v.chk_rd) check($sformatf("v%0d rdata", i), cpu_rdata, v.e_rd);
    endtask

    initial begin
        int stall_cnt;
        int req_cnt;
        bit done;

        errors = 0;
        checks = 0;
        reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_addr = 32'd0; cpu_wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset stall", {31'd0, cpu_stall}, 32'd0);
        check("reset rdata", cpu_rdata, 32'd0);
        check("reset mem_req", {31'd0, mem_req}, 32'd0);
        check("reset mem_we", {31'd0, mem_we}, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);

        //   rst rd wr addr          wd            ack mrd           st req we e_addr        e_wd          chk e_rd
        // Read miss 0x40, ack in the 3rd request cycle, then two hits.
        add(0, 1, 0, 32'h40,  32'h0,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h40,  32'h0,        0, 32'h0,        1, 1, 0, 32'h40,  32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h40,  32'h0,        0, 32'h0,        1, 1, 0, 32'h40,  32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h40,  32'h0,        1, 32'hDEADBEEF, 1, 1, 0, 32'h40,  32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h40,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 32'hDEADBEEF);
        add(0, 1, 0, 32'h40,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 32'hDEADBEEF);
        add(0, 0, 0, 32'h40,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 32'h0);
        // Write hit 0x40, ack after 1 cycle, WDONE, then read back.
        add(0, 0, 1, 32'h40,  32'hCAFEF00D, 0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        0, 32'h0);
        add(0, 0, 1, 32'h40,  32'hCAFEF00D, 1, 32'h0,        1, 1, 1, 32'h40,  32'hCAFEF00D, 0, 32'h0);
        add(0, 0, 1, 32'h40,  32'hCAFEF00D, 0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h40,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 32'hCAFEF00D);
        // Conflict: 0x440 evicts index 0, then 0x40 misses again.
        add(0, 1, 0, 32'h440, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h440, 32'h0,        1, 32'h22222222, 1, 1, 0, 32'h440, 32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h440, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 32'h22222222);
        add(0, 1, 0, 32'h40,  32'h0,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h40,  32'h0,        1, 32'h11111111, 1, 1, 0, 32'h40,  32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h40,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 32'h11111111);
        // Write miss 0x80 (ack after 2 cycles), then read 0x80 misses.
        add(0, 0, 1, 32'h80,  32'h5,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        0, 32'h0);
        add(0, 0, 1, 32'h80,  32'h5,        0, 32'h0,        1, 1, 1, 32'h80,  32'h5,        0, 32'h0);
        add(0, 0, 1, 32'h80,  32'h5,        1, 32'h0,        1, 1, 1, 32'h80,  32'h5,        0, 32'h0);
        add(0, 0, 1, 32'h80,  32'h5,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h80,  32'h0,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h80,  32'h0,        1, 32'h0BAD0080, 1, 1, 0, 32'h80,  32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h80,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 32'h0BAD0080);
        // Simultaneous read+write to 0x40 behaves as a write.
        add(0, 1, 1, 32'h40,  32'h12345678, 0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        0, 32'h0);
        add(0, 1, 1, 32'h40,  32'h12345678, 1, 32'h0,        1, 1, 1, 32'h40,  32'h12345678, 0, 32'h0);
        add(0, 1, 1, 32'h40,  32'h12345678, 0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        0, 32'h0);
        add(0, 0, 0, 32'h0,   32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 32'h0);
        // Reset mid-fill with ack in the same cycle; cached 0x80 is also lost.
        add(0, 1, 0, 32'h40,  32'h0,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h40,  32'h0,        0, 32'h0,        1, 1, 0, 32'h40,  32'h0,        0, 32'h0);
        add(1, 1, 0, 32'h40,  32'h0,        1, 32'h99999999, 1, 1, 0, 32'h40,  32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h40,  32'h0,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h40,  32'h0,        1, 32'h00000077, 1, 1, 0, 32'h40,  32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h40,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 32'h00000077);
        add(0, 1, 0, 32'h84,  32'h0,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h84,  32'h0,        1, 32'h00000055, 1, 1, 0, 32'h84,  32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h84,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 32'h00000055);
        add(0, 1, 0, 32'h40,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        1, 32'h00000077);

        for (int i = 0; i < vecs.size(); i++) run_vector(i, vecs[i]);

        // Hand sequence: read miss 0x48 with ack in the 5th request cycle.
        // Expect 6 stall cycles, 5 request cycles, then the hit.
        exp_q.push_back(32'hA5A5_0048);
        stall_cnt = 0;
        req_cnt   = 0;
        done      = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            reset = 1'b0; cpu_read = 1'b1; cpu_write = 1'b0;
            cpu_addr = 32'h48; mem_rdata = 32'hA5A5_0048;
            mem_ack = 1'b0;
            #1;
            if (mem_req) begin
                req_cnt++;
                if (mem_addr !== 32'h48) begin
                    checks++;
                    errors++;
                    $display("FAIL lat5 mem_addr: got 0x%08h expected 0x%08h", mem_addr, 32'h48);
                end
                mem_ack = (req_cnt == 5);
            end
            if (cpu_stall) begin
                stall_cnt++;
            end else begin
                done = 1'b1;
                check("lat5 rdata", cpu_rdata, exp_q.pop_front());
            end
        end
        mem_ack  = 1'b0;
        cpu_read = 1'b0;
        check("lat5 completed", {31'd0, done}, 32'd1);
        check("lat5 stall cycles", stall_cnt, 32'd6);
        check("lat5 req cycles", req_cnt, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcache_wt.md
# dcache_wt

Direct-mapped, write-through, no-write-allocate data cache between the MIPS5 pipeline's MEM stage and a slower handshaked backing memory. It replaces the single-cycle data memory port. Reads that hit return data in the same cycle. Misses and all writes stall the pipeline until the backing memory acknowledges.

## Interface
- LINES, 16, number of one-word lines; power of 2, at least 2; INDEX_BITS = log2(LINES)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- cpu_read  input  1  MEM-stage MemRead
- cpu_write  input  1  MEM-stage MemWrite
- cpu_addr  input  32  byte address (the EX/MEM ALU result); bits [1:0] ignored
- cpu_wdata  input  32  store data (the EX/MEM rt value)
- cpu_rdata  output  32  load data; valid when cpu_read=1 and cpu_stall=0
- cpu_stall  output  1  freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB
- mem_req  output  1  registered request to the backing memory
- mem_we  output  1  registered; 1 = write, 0 = read
- mem_addr  output  32  registered word-aligned address ({cpu_addr[31:2],2'b00})
- mem_wdata  output  32  registered write data
- mem_rdata  input  32  backing-memory read data; valid with mem_ack
- mem_ack  input  1  one-cycle completion pulse; ignored when mem_req=0

## Operation
- Address split: index = cpu_addr[INDEX_BITS+1:2], tag = cpu_addr[31:INDEX_BITS+2]. Each line stores valid, tag and a 32-bit data word.
- hit = valid[index] & (tag[index] == tag).
- If cpu_read and cpu_write are both 1, the access is treated as a write.
- There are three FSM states: IDLE, FILL, WDONE. WRITE is a sub-state of FILL selected by mem_we, so the FSM is effectively IDLE / BUSY / WDONE. Transitions:
  - IDLE, no access: cpu_stall=0, cpu_rdata=0.
  - IDLE, read hit: cpu_stall=0, cpu_rdata=data[index] (combinational). No state change.
  - IDLE, read miss: cpu_stall=1. At the clock edge: go to BUSY, mem_req=1, mem_we=0, latch mem_addr.
  - IDLE, write (hit or miss): cpu_stall=1. At the clock edge: go to BUSY, mem_req=1, mem_we=1, latch mem_addr and mem_wdata.
  - BUSY: cpu_stall=1. mem_req, mem_we, mem_addr and mem_wdata are held stable until the edge at which mem_ack=1. At that edge: mem_req=0, then:
    - Read: write data=mem_rdata, tag and valid=1 into the line. Go to IDLE. The stalled load then hits in IDLE.
    - Write: if the latched address hits, update the line's data to mem_wdata; a write miss does not allocate. Go to WDONE.
  - WDONE: cpu_stall=0 for exactly one cycle so the store retires. No new request is issued. Go to IDLE at the next edge.
- A read miss replaces whatever valid line already occupies that index.

## Timing
- Reset values: state=IDLE, all valid bits=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. cpu_stall and cpu_rdata are combinational and follow IDLE rules.
- Reset taken in BUSY: abandon the request (mem_req=0 at the next edge). No line is updated, even if mem_ack=1 in the same cycle.
- Read hit: 0 stall cycles.
- Read miss with ack arriving K cycles after mem_req rises (K≥1): cpu_stall=1 for K+1 cycles, then the hit cycle.
- Write with ack after K cycles: cpu_stall=1 for K+1 cycles, then 1 WDONE cycle with cpu_stall=0.
- Backing memory never sees back-to-back requests from one access. mem_req deasserts for at least 1 cycle between requests.
- Data, tag and valid arrays are updated only at the mem_ack edge. The backing memory sees all stores; the cache never holds dirty data.

## Test plan
- Read miss then hit (LINES=16): after reset, read 0x40; ack at the 3rd cycle with mem_rdata=0xDEADBEEF → mem_req=1, mem_we=0, mem_addr=0x40 for 3 cycles; cpu_stall=1 for 4 cycles; the next cycle has cpu_stall=0, cpu_rdata=0xDEADBEEF. A second read of 0x40 → 0 stall, no mem_req.
- Conflict eviction: fill 0x40 (0x11111111), then read 0x440 (same index 0) with fill 0x22222222 → miss. A following read of 0x40 misses again and issues mem_addr=0x40.
- Write hit: with 0x40 cached, write 0x40=0xCAFEF00D, ack after 1 cycle → mem_we=1, mem_wdata=0xCAFEF00D; stall 2 cycles, WDONE 1 cycle; a subsequent read of 0x40 hits and returns 0xCAFEF00D.
- Write miss, no allocate: write 0x80=0x5 after reset → memory write issued; a following read of 0x80 misses.
- Reset mid-fill: reset=1 while BUSY on a read of 0x40, with mem_ack=1 in the same cycle → mem_req=0 next cycle; a read of 0x40 afterwards misses.
- Simultaneous read+write to 0x40 → treated as a write (mem_we=1).
